// File: rtl/ser_tx_shifter.sv
// Purpose: hold the latest decimated sample and shift it out MSB-first as {fresh, overrun, data} to a mode-0 SPI master.
// Latency: first bit on sdo_o one clk after the CS_N fall is seen; each later bit one clk after the SCLK fall is seen.
// Backpressure: none; a new sample overwrites an unread one and sets sticky overrun_o.
module ser_tx_shifter #(
    parameter int DATA_W  = 16,
    parameter int FRAME_W = DATA_W + 2,
    parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    input  logic              sclk_d_i,
    input  logic              sclk_q_i,
    input  logic              csn_d_i,
    input  logic              csn_q_i,
    output logic              sdo_o,
    output logic              sdo_oe_o,
    output logic              pending_o,
    output logic              overrun_o,
    output logic              frame_done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    hold_q, hold_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic                 sdo_q, sdo_d;
    logic                 sdo_oe_q, sdo_oe_d;
    logic                 done_q, done_d;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    // Edges come straight from the two synchronizer taps (q is newer than d).
    always_comb begin
        sclk_rise = sclk_q_i & ~sclk_d_i;
        sclk_fall = ~sclk_q_i & sclk_d_i;
        cs_fall   = ~csn_q_i & csn_d_i;
        cs_rise   = csn_q_i & ~csn_d_i;
    end

    // Next-state for hold register, flags, frame FSM and registered pad outputs.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        sdo_d     = 1'b0;
        sdo_oe_d  = ~csn_q_i;
        done_d    = 1'b0;

        // A new sample always lands in the hold register; losing an unread one is sticky.
        if (data_valid_i) begin
            hold_d    = data_i;
            pending_d = 1'b1;
            if (pending_q) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    // Frame takes the old hold word; a collision sample stays pending without overrun.
                    shift_d   = {pending_q, overrun_q, hold_q};
                    cnt_d     = '0;
                    pending_d = data_valid_i;
                    overrun_d = 1'b0;
                    sdo_d     = pending_q;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    // Aborted read: the word is still unread, newer data (already in hold_d) wins.
                    pending_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    sdo_d = shift_q[FRAME_W-1];
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                            done_d  = 1'b1;
                            sdo_d   = 1'b0;
                            state_d = DONE;
                        end
                    end
                    // The fall before the first rise must not consume the first bit.
                    if (sclk_fall && (cnt_q != '0)) begin
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        sdo_d   = shift_q[FRAME_W-2];
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (csn_q_i) begin
            sdo_d = 1'b0;
        end
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            shift_q   <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            sdo_q     <= 1'b0;
            sdo_oe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            sdo_q     <= sdo_d;
            sdo_oe_q  <= sdo_oe_d;
            done_q    <= done_d;
        end
    end

    assign sdo_o        = sdo_q;
    assign sdo_oe_o     = sdo_oe_q;
    assign pending_o    = pending_q;
    assign overrun_o    = overrun_q;
    assign frame_done_o = done_q;

endmodule
